// File: rtl/exe_int_ctrl.sv
// EXE-stage interrupt controller: N maskable IRQ channels plus NMI, fixed priority,
// in-service nesting, EI shadow and a req/ack handshake to the flush unit.
module exe_int_ctrl #(
  parameter int          N_IRQ      = 4,
  parameter logic [15:0] VEC_BASE   = 16'h0038,
  parameter logic [15:0] VEC_STRIDE = 16'h0008,
  parameter logic [15:0] NMI_VEC    = 16'h0066,
  parameter logic [5:0]  OP_DI      = 6'h30,
  parameter logic [5:0]  OP_EI      = 6'h31,
  parameter logic [5:0]  OP_RETN    = 6'h32,
  parameter logic [5:0]  OP_RETI    = 6'h33
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_IRQ-1:0] extern_INT,
  input  logic             extern_NMI,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic [5:0]       opcode,
  input  logic             op_valid,
  input  logic             EOI_EXE_stage,
  input  logic             mem_pipe_stall,
  input  logic [15:0]      PC_EXE_stage,
  input  logic             int_ack,
  output logic             int_req,
  output logic             vec_valid,
  output logic [15:0]      int_vector,
  output logic [15:0]      ret_PC,
  output logic             IFF1,
  output logic             IFF2,
  output logic [N_IRQ-1:0] in_service,
  output logic             intern_INT,
  output logic             intern_NMI
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ_INT, REQ_NMI, VEC} state_t;

  state_t           state, state_next;
  logic [N_IRQ:0]   sync1, sync2, prev, rise;
  logic [N_IRQ-1:0] pending, eligible, clr_pending, set_service, reti_clr;
  logic             nmi_pending, shadow, any_eligible, op_fire;
  logic             accept_int, accept_nmi;
  logic [IDX_W-1:0] win_idx, win_next;
  logic [15:0]      chan_vector;

  assign rise        = sync2 & ~prev;
  assign op_fire     = op_valid & EOI_EXE_stage & ~mem_pipe_stall;
  assign chan_vector = VEC_BASE + 16'(win_idx) * VEC_STRIDE;
  assign int_req     = (state == REQ_INT) || (state == REQ_NMI);
  assign vec_valid   = (state == VEC);
  assign intern_INT  = IFF1 & |(pending & ~irq_mask);
  assign intern_NMI  = nmi_pending;

  // Channel k is blocked by any in-service bit at index <= k; lowest eligible index wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    logic blocked;
    blocked      = 1'b0;
    eligible     = '0;
    any_eligible = 1'b0;
    win_next     = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      blocked = blocked | in_service[k];
      eligible[k] = ~blocked & pending[k] & ~irq_mask[k] & IFF1 & ~shadow;
    end
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        any_eligible = 1'b1;
        win_next     = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_next = state;
    accept_int = 1'b0;
    accept_nmi = 1'b0;
    case (state)
      IDLE: begin
        if (nmi_pending)       state_next = REQ_NMI;
        else if (any_eligible) state_next = REQ_INT;
      end
      REQ_NMI: begin
        if (int_ack && !mem_pipe_stall) begin
          accept_nmi = 1'b1;
          state_next = VEC;
        end
      end
      REQ_INT: begin
        if (int_ack && !mem_pipe_stall) begin
          accept_int = 1'b1;
          state_next = VEC;
        end else if (nmi_pending) begin
          state_next = REQ_NMI;
        end else if (!eligible[win_idx]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign clr_pending = accept_int ? (N_IRQ'(1) << win_idx) : '0;
  assign set_service = clr_pending;
  assign reti_clr    = (op_fire && opcode == OP_RETI) ? (in_service & (~in_service + N_IRQ'(1))) : '0;

  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RST) begin
      state   <= IDLE;
      win_idx <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == REQ_INT) win_idx <= win_next;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1       <= '0;
      sync2       <= '0;
      prev        <= '0;
      pending     <= '0;
      nmi_pending <= 1'b0;
      in_service  <= '0;
      shadow      <= 1'b0;
      IFF1        <= 1'b0;
      IFF2        <= 1'b0;
      int_vector  <= '0;
      ret_PC      <= '0;
    end else begin
      sync1 <= {extern_NMI, extern_INT};
      sync2 <= sync1;
      prev  <= sync2;
      // An edge coinciding with the accept clear wins, so it is never lost.
      pending     <= (pending & ~clr_pending) | rise[N_IRQ-1:0];
      nmi_pending <= (nmi_pending & ~accept_nmi) | rise[N_IRQ];
      in_service  <= (in_service & ~reti_clr) | set_service;
      if (op_fire) shadow <= (opcode == OP_EI);

      // Interrupt entry overrides whatever the retiring instruction did to the IFFs.
      if (accept_nmi) begin
        IFF2 <= IFF1;
        IFF1 <= 1'b0;
      end else if (accept_int) begin
        IFF1 <= 1'b0;
        IFF2 <= 1'b0;
      end else if (op_fire) begin
        case (opcode)
          OP_DI:   begin IFF1 <= 1'b0; IFF2 <= 1'b0; end
          OP_EI:   begin IFF1 <= 1'b1; IFF2 <= 1'b1; end
          OP_RETN,
          OP_RETI: IFF1 <= IFF2;
          default: ;
        endcase
      end

      if (accept_nmi || accept_int) begin
        ret_PC     <= PC_EXE_stage;
        int_vector <= accept_nmi ? NMI_VEC : chan_vector;
      end
    end
  end

endmodule
